// File: rtl/mux_3_1_hls_axis_stall_detect.sv
// Per-channel AXIS stall detector feeding the deadlock monitor.
// Flags a channel once it has stalled for threshold consecutive busy cycles.
module mux_3_1_hls_axis_stall_detect #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] tvalid,
  input  logic [NUM_CH-1:0] tready,
  input  logic              inst_idle,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic [NUM_CH-1:0] stall_sticky,
  output logic [IDX_W-1:0]  first_ch,
  output logic              first_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_BLOCKED
  } st_e;

  st_e              state_q [NUM_CH];
  st_e              state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W:0]   cnt_inc [NUM_CH];

  logic [NUM_CH-1:0] xfer;
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] enter;
  logic [NUM_CH-1:0] block_q;
  logic [NUM_CH-1:0] sticky_q;
  logic [IDX_W-1:0]  first_ch_q;
  logic              first_valid_q;
  logic [IDX_W-1:0]  first_idx;
  logic              thr_on;
  logic              thr_one;

  assign thr_on  = |threshold;
  assign thr_one = (threshold == CNT_W'(1));

  always_comb begin
    xfer  = '0;
    stall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      xfer[i]  = tvalid[i] & tready[i];
      stall[i] = (tvalid[i] ^ tready[i]) & ~inst_idle & thr_on;
    end
  end

  // The extra counter bit keeps the compare correct once cnt saturates.
  always_comb begin
    enter = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
      unique case (state_q[i])
        S_IDLE: begin
          if (stall[i]) begin
            cnt_d[i]   = CNT_W'(1);
            state_d[i] = thr_one ? S_BLOCKED : S_COUNT;
          end
        end
        S_COUNT: begin
          if (xfer[i] || !stall[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_inc[i][CNT_W] ? '1 : cnt_inc[i][CNT_W-1:0];
            if (cnt_inc[i] >= {1'b0, threshold})
              state_d[i] = S_BLOCKED;
          end
        end
        S_BLOCKED: begin
          if (xfer[i] || inst_idle || !thr_on) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      enter[i] = (state_d[i] == S_BLOCKED) && (state_q[i] != S_BLOCKED);
    end
  end

  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i])
        first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      block_q       <= '0;
      sticky_q      <= '0;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        block_q[i] <= (state_d[i] == S_BLOCKED);
      end
      // A clear drops old history, but a block entering now still lands.
      if (clear) begin
        sticky_q      <= enter;
        first_valid_q <= |enter;
        first_ch_q    <= (|enter) ? first_idx : '0;
      end else begin
        sticky_q <= sticky_q | enter;
        if (!first_valid_q && (|enter)) begin
          first_valid_q <= 1'b1;
          first_ch_q    <= first_idx;
        end
      end
    end
  end

  assign axis_block_sigs = block_q;
  assign stall_sticky    = sticky_q;
  assign first_ch        = first_ch_q;
  assign first_valid     = first_valid_q;

endmodule

// File: tb/tb_mux_3_1_hls_axis_stall_detect.sv
// Randomized bench for the AXIS stall detector.
// Compares every cycle against a run-length model plus directed literals.
module tb_mux_3_1_hls_axis_stall_detect;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  tvalid;
  logic [3:0]  tready;
  logic        inst_idle;
  logic [15:0] threshold;
  logic        clear;
  logic [3:0]  axis_block_sigs;
  logic [3:0]  stall_sticky;
  logic [1:0]  first_ch;
  logic        first_valid;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [3:0] m_blk;
  logic [3:0] m_sticky;
  logic [1:0] m_fc;
  logic       m_fv;
  int         m_run [4];

  mux_3_1_hls_axis_stall_detect #(
    .NUM_CH(4),
    .CNT_W (16),
    .IDX_W (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .tvalid         (tvalid),
    .tready         (tready),
    .inst_idle      (inst_idle),
    .threshold      (threshold),
    .clear          (clear),
    .axis_block_sigs(axis_block_sigs),
    .stall_sticky   (stall_sticky),
    .first_ch       (first_ch),
    .first_valid    (first_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: a channel is blocked once its run of stall cycles reaches thr.
  always @(posedge clock) begin
    logic [3:0] ent;
    bit         st;
    bit         x;
    ent = '0;
    if (reset) begin
      m_blk    = '0;
      m_sticky = '0;
      m_fc     = '0;
      m_fv     = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        x  = tvalid[i] && tready[i];
        st = (tvalid[i] != tready[i]) && !inst_idle && (threshold != 0);
        if (m_blk[i]) begin
          if (x || inst_idle || threshold == 0) begin
            m_blk[i] = 1'b0;
            m_run[i] = 0;
          end
        end else if (st) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= int'(threshold)) begin
            m_blk[i] = 1'b1;
            ent[i]   = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (clear) begin
        m_sticky = ent;
        m_fv     = (ent != 0);
        m_fc     = '0;
        for (int i = 3; i >= 0; i--) if (ent[i]) m_fc = 2'(i);
      end else begin
        m_sticky = m_sticky | ent;
        if (!m_fv && ent != 0) begin
          m_fv = 1'b1;
          for (int i = 3; i >= 0; i--) if (ent[i]) m_fc = 2'(i);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("block", 32'(axis_block_sigs), 32'(m_blk));
      chk("sticky", 32'(stall_sticky), 32'(m_sticky));
      chk("first_valid", 32'(first_valid), 32'(m_fv));
      chk("first_ch", 32'(first_ch), 32'(m_fc));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    tvalid    = '0;
    tready    = '0;
    inst_idle = 1'b0;
    threshold = 16'd4;
    clear     = 1'b0;
    tick(2);
    started = 1'b1;
    chk("lit_reset_block", 32'(axis_block_sigs), 32'h0);
    chk("lit_reset_fv", 32'(first_valid), 32'h0);
    reset = 1'b0;

    tvalid = 4'b0001;
    tick(3);
    chk("lit_t4_early", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("lit_t4_block", 32'(axis_block_sigs), 32'h1);
    chk("lit_t4_sticky", 32'(stall_sticky), 32'h1);
    chk("lit_t4_fc", 32'(first_ch), 32'h0);
    chk("lit_t4_fv", 32'(first_valid), 32'h1);

    tready = 4'b0001;
    tick(1);
    chk("lit_xfer_drop", 32'(axis_block_sigs), 32'h0);
    chk("lit_xfer_sticky", 32'(stall_sticky), 32'h1);
    tvalid = '0;
    tready = '0;
    clear  = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("lit_clr_sticky", 32'(stall_sticky), 32'h0);
    chk("lit_clr_fv", 32'(first_valid), 32'h0);

    tready = 4'b1000;
    tick(3);
    tvalid = 4'b1000;
    tick(1);
    tvalid = '0;
    tick(3);
    chk("lit_ch3_noblk", 32'(axis_block_sigs), 32'h0);
    tready = '0;
    tick(1);

    threshold = 16'd2;
    tvalid    = 4'b0110;
    tick(1);
    chk("lit_t2_early", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("lit_t2_block", 32'(axis_block_sigs), 32'h6);
    chk("lit_t2_fc", 32'(first_ch), 32'h1);

    inst_idle = 1'b1;
    threshold = 16'd8;
    tvalid    = 4'b0100;
    tick(20);
    chk("lit_idle_noblk", 32'(axis_block_sigs), 32'h0);
    inst_idle = 1'b0;
    threshold = 16'd0;
    tick(20);
    chk("lit_thr0_noblk", 32'(axis_block_sigs), 32'h0);

    threshold = 16'd10;
    tvalid    = 4'b0001;
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("lit_rst_block", 32'(axis_block_sigs), 32'h0);
    chk("lit_rst_sticky", 32'(stall_sticky), 32'h0);
    chk("lit_rst_fv", 32'(first_valid), 32'h0);
    reset = 1'b0;
    tick(9);
    chk("lit_rst_early", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("lit_rst_block10", 32'(axis_block_sigs), 32'h1);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          tvalid[i] = 1'($urandom);
          tready[i] = 1'($urandom);
        end
      end
      inst_idle = ($urandom_range(0, 19) == 0);
      clear     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      if (c % 60 == 0) threshold = 16'($urandom_range(0, 6));
      tick(1);
    end
    reset  = 1'b0;
    clear  = 1'b0;
    tvalid = '0;
    tready = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
